// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the client and memory val/rdy/msg channels of mem_arbiter.
//   c0_req_* / c1_req_*   : client request channels   (msg = {op, addr, data, opaque})
//   c0_resp_* / c1_resp_* : client response channels  (same layout as request)
//   mem_req_* / mem_resp_*: memory server channels    (opaque widened by 1 MSB = client ID)
// Modports: slave  = the arbiter (serves clients, drives memory requests)
//           master = the surrounding system (clients and memory server)
interface mem_arbiter_if #(
  parameter int unsigned p_opaq_bits = 8
);
  localparam int unsigned LP_CMSG_W = 65 + p_opaq_bits;
  localparam int unsigned LP_MMSG_W = 66 + p_opaq_bits;

  logic                 c0_req_val;
  logic                 c0_req_rdy;
  logic [LP_CMSG_W-1:0] c0_req_msg;
  logic                 c1_req_val;
  logic                 c1_req_rdy;
  logic [LP_CMSG_W-1:0] c1_req_msg;

  logic                 c0_resp_val;
  logic                 c0_resp_rdy;
  logic [LP_CMSG_W-1:0] c0_resp_msg;
  logic                 c1_resp_val;
  logic                 c1_resp_rdy;
  logic [LP_CMSG_W-1:0] c1_resp_msg;

  logic                 mem_req_val;
  logic                 mem_req_rdy;
  logic [LP_MMSG_W-1:0] mem_req_msg;
  logic                 mem_resp_val;
  logic                 mem_resp_rdy;
  logic [LP_MMSG_W-1:0] mem_resp_msg;

  modport slave (
    input  c0_req_val, c0_req_msg, c1_req_val, c1_req_msg,
    output c0_req_rdy, c1_req_rdy,
    output c0_resp_val, c0_resp_msg, c1_resp_val, c1_resp_msg,
    input  c0_resp_rdy, c1_resp_rdy,
    output mem_req_val, mem_req_msg,
    input  mem_req_rdy,
    input  mem_resp_val, mem_resp_msg,
    output mem_resp_rdy
  );

  modport master (
    output c0_req_val, c0_req_msg, c1_req_val, c1_req_msg,
    input  c0_req_rdy, c1_req_rdy,
    input  c0_resp_val, c0_resp_msg, c1_resp_val, c1_resp_msg,
    output c0_resp_rdy, c1_resp_rdy,
    input  mem_req_val, mem_req_msg,
    output mem_req_rdy,
    output mem_resp_val, mem_resp_msg,
    input  mem_resp_rdy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client round-robin arbiter in front of a single memory server.
//   Requests are granted into a one-entry output register that drives mem_req_*;
//   the client ID is appended as the opaque MSB and used to route responses back
//   combinationally. Each client is limited to p_max_outstanding in-flight requests.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active low
//   bus  : mem_arbiter_if.slave (client request/response and memory channels)
//   perf_grants_c0/c1 : 32-bit accepted-request counters (only with MEM_ARBITER_PERF_CNT_EN)
// Optional feature macro: MEM_ARBITER_PERF_CNT_EN
module mem_arbiter #(
  parameter int unsigned p_opaq_bits       = 8,
  parameter int unsigned p_max_outstanding = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MEM_ARBITER_PERF_CNT_EN
  output logic [31:0] perf_grants_c0,
  output logic [31:0] perf_grants_c1,
`endif
  mem_arbiter_if.slave bus
);

  localparam int unsigned LP_CMSG_W = 65 + p_opaq_bits;
  localparam int unsigned LP_MMSG_W = 66 + p_opaq_bits;
  localparam int unsigned LP_CNT_W  = $clog2(p_max_outstanding + 1);

  logic                 r_full;
  logic [LP_MMSG_W-1:0] r_msg;
  logic                 r_ptr;
  logic [LP_CNT_W-1:0]  r_out0;
  logic [LP_CNT_W-1:0]  r_out1;

  logic                 w_elig0;
  logic                 w_elig1;
  logic                 w_can_accept;
  logic                 w_gnt;
  logic                 w_gnt_id;
  logic                 w_gnt0;
  logic                 w_gnt1;
  logic [LP_CMSG_W-1:0] w_sel_msg;
  logic [LP_MMSG_W-1:0] w_new_msg;
  logic                 w_resp_id;
  logic [LP_CMSG_W-1:0] w_resp_msg;
  logic                 w_rx0;
  logic                 w_rx1;

  // Saturating up/down counter; simultaneous inc and dec cancel out.
  function automatic logic [LP_CNT_W-1:0] f_next_cnt(
    input logic [LP_CNT_W-1:0] cnt,
    input logic                inc,
    input logic                dec
  );
    logic [LP_CNT_W-1:0] nxt;
    nxt = cnt;
    if (inc && !dec)
      nxt = cnt + LP_CNT_W'(1);
    else if (dec && !inc && (cnt != '0))
      nxt = cnt - LP_CNT_W'(1);
    return nxt;
  endfunction

  // Arbitration: pointer breaks ties, a lone eligible requester always wins.
  always_comb begin
    w_elig0      = bus.c0_req_val && (r_out0 < LP_CNT_W'(p_max_outstanding));
    w_elig1      = bus.c1_req_val && (r_out1 < LP_CNT_W'(p_max_outstanding));
    w_can_accept = !r_full || bus.mem_req_rdy;
    w_gnt_id     = (w_elig0 && w_elig1) ? r_ptr : w_elig1;
    w_gnt        = rst && w_can_accept && (w_elig0 || w_elig1);
    w_gnt0       = w_gnt && !w_gnt_id;
    w_gnt1       = w_gnt &&  w_gnt_id;
    w_sel_msg    = w_gnt_id ? bus.c1_req_msg : bus.c0_req_msg;
    w_new_msg    = {w_sel_msg[LP_CMSG_W-1:p_opaq_bits], w_gnt_id,
                    w_sel_msg[p_opaq_bits-1:0]};
  end

  assign bus.c0_req_rdy  = w_gnt0;
  assign bus.c1_req_rdy  = w_gnt1;
  assign bus.mem_req_val = r_full;
  assign bus.mem_req_msg = r_msg;

  // Response path: route by opaque MSB and strip it.
  always_comb begin
    w_resp_id  = bus.mem_resp_msg[p_opaq_bits];
    w_resp_msg = {bus.mem_resp_msg[LP_MMSG_W-1:p_opaq_bits+1],
                  bus.mem_resp_msg[p_opaq_bits-1:0]};
    w_rx0      = bus.mem_resp_val && !w_resp_id && bus.c0_resp_rdy;
    w_rx1      = bus.mem_resp_val &&  w_resp_id && bus.c1_resp_rdy;
  end

  assign bus.c0_resp_val  = bus.mem_resp_val && !w_resp_id;
  assign bus.c1_resp_val  = bus.mem_resp_val &&  w_resp_id;
  assign bus.c0_resp_msg  = w_resp_msg;
  assign bus.c1_resp_msg  = w_resp_msg;
  assign bus.mem_resp_rdy = w_resp_id ? bus.c1_resp_rdy : bus.c0_resp_rdy;

  // Output register, priority pointer and outstanding counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_full <= 1'b0;
      r_msg  <= '0;
      r_ptr  <= 1'b0;
      r_out0 <= '0;
      r_out1 <= '0;
    end else begin
      if (w_gnt) begin
        r_full <= 1'b1;
        r_msg  <= w_new_msg;
        r_ptr  <= ~w_gnt_id;
      end else if (bus.mem_req_rdy) begin
        r_full <= 1'b0;
      end
      r_out0 <= f_next_cnt(r_out0, w_gnt0, w_rx0);
      r_out1 <= f_next_cnt(r_out1, w_gnt1, w_rx1);
    end
  end

`ifdef MEM_ARBITER_PERF_CNT_EN
  // Per-client accepted-request counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_grants_c0 <= '0;
      perf_grants_c1 <= '0;
    end else begin
      if (w_gnt0) perf_grants_c0 <= perf_grants_c0 + 32'd1;
      if (w_gnt1) perf_grants_c1 <= perf_grants_c1 + 32'd1;
    end
  end
`else
  // Grant counters not built.
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a memory-request scoreboard.
module tb_mem_arbiter;

  localparam int unsigned LP_W    = 8;
  localparam int unsigned LP_CW   = 65 + LP_W;
  localparam int unsigned LP_MW   = 66 + LP_W;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  logic [LP_MW-1:0] sb_q[$];

  mem_arbiter_if #(.p_opaq_bits(LP_W)) bus ();

`ifdef MEM_ARBITER_PERF_CNT_EN
  logic [31:0] perf_grants_c0;
  logic [31:0] perf_grants_c1;
`endif

  mem_arbiter #(.p_opaq_bits(LP_W), .p_max_outstanding(4)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef MEM_ARBITER_PERF_CNT_EN
    .perf_grants_c0 (perf_grants_c0),
    .perf_grants_c1 (perf_grants_c1),
`endif
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [LP_CW-1:0] mk(input logic op, input logic [31:0] addr,
                                           input logic [31:0] data, input logic [LP_W-1:0] opq);
    return {op, addr, data, opq};
  endfunction

  function automatic logic [LP_MW-1:0] widen(input logic [LP_CW-1:0] m, input logic id);
    return {m[LP_CW-1:LP_W], id, m[LP_W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Scoreboard: expected memory requests pushed on client acceptance, popped on drain.
  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
    end else begin
      if (bus.mem_req_val && bus.mem_req_rdy) begin
        chk("sb_nonempty", 128'(sb_q.size() != 0), 128'd1);
        if (sb_q.size() != 0)
          chk("sb_mem_req", 128'(bus.mem_req_msg), 128'(sb_q.pop_front()));
      end
      if (bus.c0_req_val && bus.c0_req_rdy) sb_q.push_back(widen(bus.c0_req_msg, 1'b0));
      if (bus.c1_req_val && bus.c1_req_rdy) sb_q.push_back(widen(bus.c1_req_msg, 1'b1));
    end
  end

  initial begin
    logic [LP_CW-1:0] m_a;
    logic [LP_CW-1:0] m_b;
    logic [LP_CW-1:0] m_c;
    n_checks = 0;
    n_pass   = 0;
    rst              = 1'b0;
    bus.c0_req_val   = 1'b1;
    bus.c1_req_val   = 1'b1;
    bus.c0_req_msg   = mk(1'b0, 32'h0, 32'h0, 8'h01);
    bus.c1_req_msg   = mk(1'b1, 32'h4, 32'h5, 8'h02);
    bus.c0_resp_rdy  = 1'b1;
    bus.c1_resp_rdy  = 1'b1;
    bus.mem_req_rdy  = 1'b0;
    bus.mem_resp_val = 1'b0;
    bus.mem_resp_msg = '0;

    // Reset state with both clients requesting
    smp();
    chk("rst_c0_rdy", 128'(bus.c0_req_rdy), 128'd0);
    chk("rst_c1_rdy", 128'(bus.c1_req_rdy), 128'd0);
    chk("rst_mem_val", 128'(bus.mem_req_val), 128'd0);
    chk("rst_ptr", 128'(dut.r_ptr), 128'd0);
    tick();
    rst = 1'b1;
    bus.c0_req_val = 1'b0;
    bus.c1_req_val = 1'b0;

    // Single client-0 read and its response
    m_a = mk(1'b0, 32'h100, 32'h0, 8'h12);
    bus.c0_req_val  = 1'b1;
    bus.c0_req_msg  = m_a;
    bus.mem_req_rdy = 1'b1;
    smp();
    chk("t1_c0_rdy", 128'(bus.c0_req_rdy), 128'd1);
    tick();
    bus.c0_req_val = 1'b0;
    smp();
    chk("t1_mem_val", 128'(bus.mem_req_val), 128'd1);
    chk("t1_opaq", 128'(bus.mem_req_msg[LP_W:0]), 128'h012);
    chk("t1_msg", 128'(bus.mem_req_msg), 128'(widen(m_a, 1'b0)));
    tick();
    m_b = mk(1'b0, 32'h100, 32'hdead_beef, 8'h12);
    bus.mem_resp_val = 1'b1;
    bus.mem_resp_msg = widen(m_b, 1'b0);
    smp();
    chk("t1_c0_resp_val", 128'(bus.c0_resp_val), 128'd1);
    chk("t1_c0_resp_msg", 128'(bus.c0_resp_msg), 128'(m_b));
    chk("t1_c1_resp_val", 128'(bus.c1_resp_val), 128'd0);
    chk("t1_mem_resp_rdy", 128'(bus.mem_resp_rdy), 128'd1);
    chk("t1_mem_idle", 128'(bus.mem_req_val), 128'd0);
    tick();
    bus.mem_resp_val = 1'b0;
    smp();
    chk("t1_out0", 128'(dut.r_out0), 128'd0);
    tick();

    // Round-robin with both clients requesting continuously
    do_reset();
    bus.c0_req_val = 1'b1;
    bus.c1_req_val = 1'b1;
    bus.c0_req_msg = mk(1'b0, 32'h200, 32'h0, 8'h21);
    bus.c1_req_msg = mk(1'b1, 32'h300, 32'h33, 8'h31);
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("rr_c0_rdy", 128'(bus.c0_req_rdy), (i % 2 == 0) ? 128'd1 : 128'd0);
      chk("rr_c1_rdy", 128'(bus.c1_req_rdy), (i % 2 == 1) ? 128'd1 : 128'd0);
      if (i > 0)
        chk("rr_msb", 128'(bus.mem_req_msg[LP_W]), ((i - 1) % 2 == 1) ? 128'd1 : 128'd0);
      tick();
    end
    bus.c0_req_val = 1'b0;
    bus.c1_req_val = 1'b0;
    smp();
    chk("rr_msb_last", 128'(bus.mem_req_msg[LP_W]), 128'd1);
    tick();

    // Back-pressure: register full, mem_req_rdy low for 5 cycles
    do_reset();
    bus.mem_req_rdy = 1'b0;
    m_a = mk(1'b0, 32'h400, 32'h0, 8'h41);
    m_b = mk(1'b1, 32'h404, 32'h44, 8'h42);
    m_c = mk(1'b1, 32'h500, 32'h55, 8'h51);
    bus.c0_req_val = 1'b1;
    bus.c0_req_msg = m_a;
    smp();
    chk("bp_first_rdy", 128'(bus.c0_req_rdy), 128'd1);
    tick();
    bus.c0_req_msg = m_b;
    bus.c1_req_val = 1'b1;
    bus.c1_req_msg = m_c;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("bp_val", 128'(bus.mem_req_val), 128'd1);
      chk("bp_msg", 128'(bus.mem_req_msg), 128'(widen(m_a, 1'b0)));
      chk("bp_c0_rdy", 128'(bus.c0_req_rdy), 128'd0);
      chk("bp_c1_rdy", 128'(bus.c1_req_rdy), 128'd0);
      tick();
    end
    bus.mem_req_rdy = 1'b1;
    smp();
    chk("bp_drain_c1_rdy", 128'(bus.c1_req_rdy), 128'd1);
    chk("bp_drain_c0_rdy", 128'(bus.c0_req_rdy), 128'd0);
    tick();
    bus.c0_req_val = 1'b0;
    bus.c1_req_val = 1'b0;
    smp();
    chk("bp_next_msg", 128'(bus.mem_req_msg), 128'(widen(m_c, 1'b1)));
    tick();

    // Outstanding limit on client 1, plus a stray client-0 response
    do_reset();
    bus.mem_req_rdy = 1'b1;
    bus.c1_req_val  = 1'b1;
    bus.c1_req_msg  = mk(1'b1, 32'h600, 32'h66, 8'h61);
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("lim_c1_rdy", 128'(bus.c1_req_rdy), 128'd1);
      tick();
    end
    smp();
    chk("lim_c1_blocked", 128'(bus.c1_req_rdy), 128'd0);
    tick();
    m_a = mk(1'b0, 32'h700, 32'h77, 8'h71);
    bus.mem_resp_val = 1'b1;
    bus.mem_resp_msg = widen(m_a, 1'b0);
    smp();
    chk("stray_c0_resp_val", 128'(bus.c0_resp_val), 128'd1);
    chk("stray_c0_resp_msg", 128'(bus.c0_resp_msg), 128'(m_a));
    chk("stray_c1_resp_val", 128'(bus.c1_resp_val), 128'd0);
    tick();
    m_b = mk(1'b1, 32'h600, 32'h99, 8'h61);
    bus.mem_resp_msg = widen(m_b, 1'b1);
    smp();
    chk("stray_out0", 128'(dut.r_out0), 128'd0);
    chk("lim_c1_resp_val", 128'(bus.c1_resp_val), 128'd1);
    chk("lim_c1_resp_msg", 128'(bus.c1_resp_msg), 128'(m_b));
    chk("lim_c0_resp_val", 128'(bus.c0_resp_val), 128'd0);
    chk("lim_still_blocked", 128'(bus.c1_req_rdy), 128'd0);
    tick();
    bus.mem_resp_val = 1'b0;
    smp();
    chk("lim_c1_reopen", 128'(bus.c1_req_rdy), 128'd1);
    tick();
    bus.c1_req_val = 1'b0;
    smp();
    chk("lim_out1", 128'(dut.r_out1), 128'd4);
    tick();

    // Reset while the output register is full
    do_reset();
    bus.mem_req_rdy = 1'b0;
    bus.c0_req_val  = 1'b1;
    bus.c0_req_msg  = mk(1'b0, 32'h800, 32'h0, 8'h81);
    smp();
    chk("mr_c0_rdy", 128'(bus.c0_req_rdy), 128'd1);
    tick();
    rst = 1'b0;
    bus.c1_req_val = 1'b1;
    smp();
    chk("mr_rst_c0_rdy", 128'(bus.c0_req_rdy), 128'd0);
    chk("mr_rst_c1_rdy", 128'(bus.c1_req_rdy), 128'd0);
    tick();
    rst = 1'b1;
    bus.c0_req_val = 1'b0;
    bus.c1_req_val = 1'b0;
    smp();
    chk("mr_mem_val", 128'(bus.mem_req_val), 128'd0);
    chk("mr_ptr", 128'(dut.r_ptr), 128'd0);
    chk("mr_out0", 128'(dut.r_out0), 128'd0);
    chk("mr_out1", 128'(dut.r_out1), 128'd0);
    tick();
    bus.mem_req_rdy = 1'b1;
    smp();
    chk("mr_no_replay", 128'(bus.mem_req_val), 128'd0);
    tick();
    bus.c0_req_val = 1'b1;
    bus.c1_req_val = 1'b1;
    smp();
    chk("mr_fav_c0", 128'(bus.c0_req_rdy), 128'd1);
    chk("mr_fav_c1", 128'(bus.c1_req_rdy), 128'd0);
    tick();
    bus.c0_req_val = 1'b0;
    bus.c1_req_val = 1'b0;
    smp();
    chk("mr_msb", 128'(bus.mem_req_msg[LP_W]), 128'd0);
    tick();

`ifdef MEM_ARBITER_PERF_CNT_EN
    // Grant counters: 3 for client 0, 2 for client 1
    do_reset();
    bus.mem_req_rdy = 1'b1;
    bus.c0_req_val  = 1'b1;
    bus.c1_req_val  = 1'b1;
    repeat (4) tick();
    bus.c1_req_val = 1'b0;
    tick();
    bus.c0_req_val = 1'b0;
    smp();
    chk("perf_c0", 128'(perf_grants_c0), 128'd3);
    chk("perf_c1", 128'(perf_grants_c1), 128'd2);
    tick();
`endif

    repeat (3) tick();
    smp();
    chk("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter p_opaq_bits, default 8: width of the client opaque field.
REQ-002 SHALL have parameter p_max_outstanding, default 4: maximum number of in-flight requests per client.
REQ-003 SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst, input, 1 bit: reset, synchronous and active-low (asserted when 0).
REQ-005 SHALL have c0_req_val / c0_req_rdy, input / output, 1 bit each: client 0 (instruction side) request handshake.
REQ-006 SHALL have c0_req_msg, input, 65+p_opaq_bits bits: {op[0] (0 = read, 1 = write), addr[31:0], data[31:0], opaque}.
REQ-007 SHALL have c1_req_val, c1_req_rdy and c1_req_msg: same as REQ-005/006, for client 1 (data side).
REQ-008 SHALL have c0_resp_val / c0_resp_rdy and c1_resp_val / c1_resp_rdy, output / input, 1 bit each: response handshakes to the clients.
REQ-009 SHALL have c0_resp_msg and c1_resp_msg, output, 65+p_opaq_bits bits: same layout as the request message.
REQ-010 SHALL have mem_req_val / mem_req_rdy, output / input, 1 bit each: request handshake to the memory server.
REQ-011 SHALL have mem_req_msg, output, 66+p_opaq_bits bits: client message with the opaque field widened by 1 MSB, the client ID.
REQ-012 SHALL have mem_resp_val / mem_resp_rdy, input / output, 1 bit each: memory response handshake.
REQ-013 SHALL have mem_resp_msg, input, 66+p_opaq_bits bits: memory response, same layout as mem_req_msg.

Function
REQ-014 SHALL treat a transfer as having occurred on a cycle only when val and rdy are both high that cycle.
REQ-015 SHALL hold each granted request in a one-entry output register.
- The register drives mem_req_*.
- Latency from client acceptance to mem_req_val high SHALL be exactly 1 cycle.
REQ-016 SHALL accept a new request when the register is empty, or when it is being drained that same cycle (mem_req_rdy high).
REQ-017 SHALL raise cN_req_rdy only when client N wins arbitration, the register can accept, and outstanding[N] < p_max_outstanding.
REQ-018 SHALL arbitrate round-robin.
- A 1-bit priority pointer names the favoured client.
- After a grant to client N, the pointer SHALL point to client 1-N.
- The pointer SHALL NOT change on cycles with no grant.
REQ-019 SHALL grant a lone requester regardless of the pointer, provided its outstanding limit allows.
REQ-020 SHALL keep mem_req_msg stable and mem_req_val high while the register is full and mem_req_rdy is low.
REQ-021 SHALL set the widened opaque MSB to the granted client ID and pass the lower p_opaq_bits unchanged.
REQ-022 SHALL route each memory response by opaque MSB to client 0 or 1.
- The MSB SHALL be stripped before delivery.
- The response path SHALL be combinational, with mem_resp_rdy equal to the selected client's cN_resp_rdy.
REQ-023 SHALL keep a per-client outstanding counter, $clog2(p_max_outstanding+1) bits wide.
- Increment on a cN_req transfer; decrement on a cN_resp transfer.
- Both in the same cycle SHALL leave the counter unchanged.
- The counter SHALL never wrap.
REQ-024 SHALL, when a response returns for a client whose counter is 0, leave the counter at 0 and still deliver the response.

Reset
REQ-025 SHALL, on rst low at a clock edge, apply:
- output register empty, so mem_req_val = 0;
- priority pointer = 0 (client 0 favoured);
- both outstanding counters = 0.
REQ-026 SHALL hold all cN_req_rdy low during reset.
REQ-027 SHALL discard, and not replay, a request held in the output register when reset is asserted mid-operation.

Configuration
REQ-028 SHALL, with MEM_ARBITER_PERF_CNT_EN defined, provide two 32-bit outputs, perf_grants_c0 and perf_grants_c1.
- Each counts accepted requests for its client and wraps at 2^32.
- Both clear on reset.
- Each counts +1 per transfer, including on a same-cycle drain.
REQ-029 SHALL, with MEM_ARBITER_PERF_CNT_EN undefined, omit these ports and counters entirely; all other behaviour SHALL be identical.

Verification
REQ-030 SHALL cover a single client-0 read of addr 0x100, opaque 0x12, with mem_req_rdy high.
- Required: mem_req_val high one cycle later, opaque 0x012.
- Then a memory response with opaque 0x012 SHALL reach c0_resp with opaque 0x12, and c1_resp_val SHALL stay 0.
REQ-031 SHALL cover both clients requesting continuously after reset, with mem_req_rdy always high.
- Required grant order: c0, c1, c0, c1.
- The opaque MSB sequence on mem_req SHALL be 0, 1, 0, 1.
REQ-032 SHALL cover mem_req_rdy held low for 5 cycles with the register full.
- mem_req_msg SHALL stay unchanged and both cN_req_rdy SHALL stay 0.
- The transfer SHALL complete on the cycle rdy rises, and a new grant SHALL be accepted that same cycle.
REQ-033 SHALL cover client 1 issuing 4 writes with no responses, using p_max_outstanding = 4.
- c1_req_rdy SHALL go 0.
- After one response to c1, c1_req_rdy SHALL return to 1 on the next arbitration.
REQ-034 SHALL cover rst driven low for 1 cycle while the register is full.
- mem_req_val SHALL be 0 the next cycle, with the counters and pointer at their reset values.
REQ-035 SHALL cover, with MEM_ARBITER_PERF_CNT_EN defined, 3 c0 grants and 2 c1 grants.
- Required: perf_grants_c0 = 3 and perf_grants_c1 = 2.
